display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller.sv | 213 +++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Multiplexed LED-matrix column scanner. One column is lit at a time for
// DWELL_CYCLES clocks. Each column is followed by a single all-off blanking
// cycle so that ghosting between columns is suppressed. A new frame is
// accepted through a valid/ready handshake into a pending register. It is
// moved into the displayed (shadow) register only at a frame boundary, or
// immediately while idle, so a frame is never torn mid-scan.
//
// Optional feature (macro DISPLAY_SCAN_BLINK_EN):
//   When defined, a frame counter drives a blink phase that toggles every
//   BLINK_FRAMES frames. While the phase is 1, columns selected by blink_mask
//   show all rows off. When undefined, blink_mask is ignored.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   enable       scanning runs while high
//   frame_data   DATA_WIDTH frame, column k at bits [COLUNE_SIZE*k +: COLUNE_SIZE]
//   frame_valid  frame_data offered
//   frame_ready  pending slot is free (registered, no input path)
//   blink_mask   per-column blink request
//   column_sel   active-low one-hot column drive
//   row_data     active-low row drive for the lit column
//   frame_done   one-cycle pulse in the blanking cycle after the last column
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int DATA_WIDTH    = 35,
  parameter int DWELL_CYCLES  = 50000,
  parameter int BLINK_FRAMES  = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_WIDTH-1:0]    frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  logic [TOTAL_COLUNES-1:0] blink_mask,
  output logic [TOTAL_COLUNES-1:0] column_sel,
  output logic [COLUNE_SIZE-1:0]   row_data,
  output logic                     frame_done
);

  localparam int IDX_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
  localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TOTAL_COLUNES - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DW_W-1:0]         dwell_q, dwell_d;
  logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0]   pending_q, pending_d;
  logic                    pending_full_q, pending_full_d;
  logic [COLUNE_SIZE-1:0]  col_rows;

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            col_blink;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
`endif

  // The pending slot is the only flow-control resource.
  assign frame_ready = ~pending_full_q;

  // Sequencing, handshake and frame swap
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    dwell_d        = dwell_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;

    frame_done = (state_q == ST_BLANK) && (idx_q == IDX_LAST);

    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        dwell_d = '0;
        if (enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      ST_BLANK: begin
        dwell_d = '0;
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          state_d = ST_SCAN;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end
    endcase

    // Swap and capture are mutually exclusive: swap needs a full slot,
    // capture needs an empty one. The shadow therefore only changes at a
    // frame boundary or while idle.
    if (pending_full_q && ((state_q == ST_IDLE) || frame_done)) begin
      shadow_d       = pending_q;
      pending_full_d = 1'b0;
    end
    if (frame_valid && !pending_full_q) begin
      pending_d      = frame_data;
      pending_full_d = 1'b1;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  // Blink phase advances once every BLINK_FRAMES completed frames and
  // restarts from phase 0 whenever scanning stops.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (state_q == ST_IDLE) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_done) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end
`endif

  // Output decode straight from registered state
  always_comb begin
    column_sel = '1;
    row_data   = '1;
    col_rows   = '1;
`ifdef DISPLAY_SCAN_BLINK_EN
    col_blink  = 1'b0;
`endif
    for (int k = 0; k < TOTAL_COLUNES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        col_rows = shadow_q[k*COLUNE_SIZE +: COLUNE_SIZE];
`ifdef DISPLAY_SCAN_BLINK_EN
        col_blink = blink_mask[k];
`endif
      end
    end
    if (state_q == ST_SCAN) begin
      for (int k = 0; k < TOTAL_COLUNES; k++) begin
        column_sel[k] = (idx_q != IDX_W'(k));
      end
      row_data = ~col_rows;
`ifdef DISPLAY_SCAN_BLINK_EN
      if (blink_phase_q && col_blink) row_data = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      dwell_q        <= '0;
      shadow_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      dwell_q        <= dwell_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
`ifdef DISPLAY_SCAN_BLINK_EN
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
`endif
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//
// Directed bench for display_scan_controller with DWELL_CYCLES=4 and
// BLINK_FRAMES=2. A frame-level reference model tracks time since scan start,
// the shown frame and the pending slot. Every cycle after reset, column_sel,
// row_data, frame_done and frame_ready are compared against that model.
// Literal expectations at key points anchor the model.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

  localparam int CS    = 7;
  localparam int NC    = 5;
  localparam int DW    = 35;
  localparam int DWELL = 4;
  localparam int BLINK = 2;
  localparam int PER   = NC * (DWELL + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          frame_valid = 1'b0;
  logic [DW-1:0] frame_data = '0;
  logic [NC-1:0] blink_mask = 5'b00100;
  logic          frame_ready;
  logic          frame_done;
  logic [NC-1:0] column_sel;
  logic [CS-1:0] row_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .COLUNE_SIZE  (CS),
    .TOTAL_COLUNES(NC),
    .DATA_WIDTH   (DW),
    .DWELL_CYCLES (DWELL),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .blink_mask (blink_mask),
    .column_sel (column_sel),
    .row_data   (row_data),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  bit            m_on = 1'b0;
  bit            m_run = 1'b0;
  int            m_t = 0;
  int            m_frames = 0;
  logic [DW-1:0] m_shadow = '0;
  logic [DW-1:0] m_pending = '0;
  bit            m_pfull = 1'b0;

  initial begin
    bit fd, take;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_on = 1'b1; m_run = 1'b0; m_t = 0; m_frames = 0;
        m_shadow = '0; m_pending = '0; m_pfull = 1'b0;
      end else if (m_on) begin
        fd   = m_run && ((m_t % PER) == PER - 1);
        take = frame_valid && !m_pfull;
        if (m_pfull && (!m_run || fd)) begin
          m_shadow = m_pending;
          m_pfull  = 1'b0;
        end
        if (take) begin
          m_pending = frame_data;
          m_pfull   = 1'b1;
        end
        if (!enable) begin
          m_run = 1'b0; m_t = 0; m_frames = 0;
        end else if (!m_run) begin
          m_run = 1'b1; m_t = 0;
        end else begin
          if (fd) m_frames++;
          m_t++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [NC-1:0] e_col;
    logic [CS-1:0] e_row;
    logic          e_fd;
    int pos, c, w;
    forever begin
      @(negedge clk);
      if (m_on) begin
        e_col = '1; e_row = '1; e_fd = 1'b0;
        if (m_run) begin
          pos = m_t % PER;
          c   = pos / (DWELL + 1);
          w   = pos % (DWELL + 1);
          if (w < DWELL) begin
            e_col[c] = 1'b0;
            e_row    = ~CS'(m_shadow >> (CS * c));
`ifdef DISPLAY_SCAN_BLINK_EN
            if (((m_frames / BLINK) % 2) == 1 && blink_mask[c]) e_row = '1;
`endif
          end else begin
            e_fd = (c == NC - 1);
          end
        end
        check("model_column_sel", 64'(column_sel), 64'(e_col));
        check("model_row_data", 64'(row_data), 64'(e_row));
        check("model_frame_done", 64'(frame_done), 64'(e_fd));
        check("model_frame_ready", 64'(frame_ready), 64'(!m_pfull));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd(input string name, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_done !== 1'b1 && n < 4 * PER);
    if (frame_done !== 1'b1) timeout(name);
  endtask

  task automatic offer(input logic [DW-1:0] d, input string name);
    int n;
    n = 0;
    frame_valid = 1'b1;
    frame_data  = d;
    while (frame_ready !== 1'b1 && n < 4 * PER) begin
      step(1);
      n++;
    end
    if (frame_ready !== 1'b1) timeout(name);
    step(1);
    frame_valid = 1'b0;
  endtask

  initial begin
    int n;

    // Reset values
    reset = 1'b1;
    step(3);
    check("rst_column_sel", 64'(column_sel), 64'h1F);
    check("rst_row_data", 64'(row_data), 64'h7F);
    check("rst_frame_ready", 64'(frame_ready), 64'h1);
    check("rst_frame_done", 64'(frame_done), 64'h0);
    reset = 1'b0;
    step(2);

    // Start scanning: column sequence and frame period
    enable = 1'b1;
    step(1);
    for (int i = 0; i < DWELL; i++) begin
      check("start_col0", 64'(column_sel), 64'b11110);
      step(1);
    end
    check("start_blank0", 64'(column_sel), 64'b11111);
    step(1);
    check("start_col1", 64'(column_sel), 64'b11101);
    wait_fd("first_frame_done", n);
    check("first_frame_done_wait", 64'(n), 64'd19);
    wait_fd("second_frame_done", n);
    check("frame_period", 64'(n), 64'd25);

    // Frame offered mid-frame
    step(7);
    frame_valid = 1'b1;
    frame_data  = 35'h0000000FF;
    step(1);
    frame_valid = 1'b0;
    check("ready_drop", 64'(frame_ready), 64'h0);
    wait_fd("swap_frame_done", n);
    step(1);
    check("swap_col0_sel", 64'(column_sel), 64'b11110);
    check("swap_col0_rows", 64'(row_data), 64'b0000000);
    check("swap_ready_back", 64'(frame_ready), 64'h1);
    step(DWELL + 1);
    check("swap_col1_sel", 64'(column_sel), 64'b11101);
    check("swap_col1_rows", 64'(row_data), 64'b1111110);

    // Two frames back to back: second waits for the swap
    step(3);
    offer(35'h1_2345_6789, "offer_f1");
    offer(35'h5_5AA5_3C3C, "offer_f2");
    check("f2_held_ready", 64'(frame_ready), 64'h0);
    wait_fd("f2_swap", n);
    step(1);
    check("f2_col0_rows", 64'(row_data), 64'h43);
    wait_fd("f2_shown", n);

    // Disable during column 2, then restart
    n = 0;
    while (column_sel !== 5'b11011 && n < 2 * PER) begin
      step(1);
      n++;
    end
    if (column_sel !== 5'b11011) timeout("reach_col2");
    step(1);
    enable = 1'b0;
    step(1);
    check("disable_col", 64'(column_sel), 64'h1F);
    check("disable_rows", 64'(row_data), 64'h7F);
    step(3);
    enable = 1'b1;
    step(1);
    for (int i = 0; i < DWELL; i++) begin
      check("restart_col0", 64'(column_sel), 64'b11110);
      step(1);
    end
    check("restart_blank", 64'(column_sel), 64'b11111);

    // Long run covering several blink periods
    for (int i = 0; i < 9; i++) wait_fd("long_run", n);

    // Reset while a frame is pending
    step(6);
    offer(35'h7_FFFF_FFFF, "offer_before_reset");
    check("pending_before_reset", 64'(frame_ready), 64'h0);
    step(2);
    reset = 1'b1;
    step(1);
    check("midrst_frame_ready", 64'(frame_ready), 64'h1);
    check("midrst_column_sel", 64'(column_sel), 64'h1F);
    check("midrst_row_data", 64'(row_data), 64'h7F);
    check("midrst_frame_done", 64'(frame_done), 64'h0);
    reset = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
